// File: rtl/qed_dup_replay.sv
// Capture/replay stage issuing SQED duplicates remapped to x16-x31.
// Define QED_OVERFLOW_FLAG_EN to add the sticky qed_overflow output.
module qed_dup_replay #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              stall_IF,
  input  logic              exec_dup,
  input  logic [31:0]       ifu_qed_instruction,
  output logic [31:0]       qed_ifu_instruction,
  output logic              qed_vld_out,
  output logic [ADDR_W:0]   num_orig,
  output logic [ADDR_W:0]   num_dup,
  output logic              qed_ready
`ifdef QED_OVERFLOW_FLAG_EN
  ,
  output logic              qed_overflow
`endif
);

  localparam logic [31:0]     NOP  = 32'h0000_007F;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {ORIG, DUP, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     norig_q, norig_d;
  logic [ADDR_W:0]     ndup_q, ndup_d;
  logic [31:0]         out_q, out_d;
  logic                vld_q, vld_d;
  logic                rdy_q, rdy_d;
  logic                we;
  logic [31:0]         rb_q [DEPTH];
`ifdef QED_OVERFLOW_FLAG_EN
  logic                ovf_q, ovf_d;
`endif

  // Setting bit 4 of a register field moves x0-x15 to x16-x31;
  // bit 30 adds 1024 to the load/store offset (upper memory half).
  function automatic logic [31:0] modify(input logic [31:0] i);
    logic [31:0] m;
    m = i;
    case (i[6:0])
      7'h33: begin m[11] = 1'b1; m[19] = 1'b1; m[24] = 1'b1; end
      7'h13: begin m[11] = 1'b1; m[19] = 1'b1; end
      7'h03: begin m[11] = 1'b1; m[30] = 1'b1; end
      7'h23: begin m[24] = 1'b1; m[30] = 1'b1; end
      default: ;
    endcase
    return m;
  endfunction

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    norig_d  = norig_q;
    ndup_d   = ndup_q;
    out_d    = out_q;
    vld_d    = vld_q;
    we       = 1'b0;
`ifdef QED_OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif
    if (!stall_IF) begin
      if (!ena) begin
        out_d = ifu_qed_instruction;
        vld_d = 1'b1;
      end else begin
        case (state_q)
          ORIG: begin
            if (exec_dup && norig_q != '0) begin
              state_d = DUP;
              out_d   = NOP;
              vld_d   = 1'b0;
            end else if (ifu_qed_instruction[6:0] == 7'h7F) begin
              out_d = ifu_qed_instruction;
              vld_d = 1'b0;
            end else if (norig_q != FULL) begin
              out_d    = ifu_qed_instruction;
              vld_d    = 1'b1;
              we       = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              norig_d  = norig_q + ONE;
            end else begin
              out_d = NOP;
              vld_d = 1'b0;
`ifdef QED_OVERFLOW_FLAG_EN
              ovf_d = 1'b1;
`endif
            end
          end
          DUP: begin
            out_d    = modify(rb_q[rd_ptr_q]);
            vld_d    = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            ndup_d   = ndup_q + ONE;
            if (ndup_q + ONE == norig_q) state_d = DONE;
          end
          DONE: begin
            out_d = NOP;
            vld_d = 1'b0;
          end
          default: state_d = ORIG;
        endcase
      end
    end
    rdy_d = (norig_d == ndup_d) && (norig_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ORIG;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      norig_q  <= '0;
      ndup_q   <= '0;
      out_q    <= NOP;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef QED_OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      norig_q  <= norig_d;
      ndup_q   <= ndup_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      rdy_q    <= rdy_d;
`ifdef QED_OVERFLOW_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Buffer contents survive reset; only pointers/counts are cleared.
  always_ff @(posedge clk) begin
    if (!rst && we) rb_q[wr_ptr_q] <= ifu_qed_instruction;
  end

  assign qed_ifu_instruction = out_q;
  assign qed_vld_out         = vld_q;
  assign num_orig            = norig_q;
  assign num_dup             = ndup_q;
  assign qed_ready           = rdy_q;
`ifdef QED_OVERFLOW_FLAG_EN
  assign qed_overflow        = ovf_q;
`endif

endmodule
